// File: rtl/cpu_sequencer_if.sv
// Bundle of the control, handshake, decode and status signals between the
// CPU sequencer and the rest of the core.
interface cpu_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             stop;
  logic             imem_ack;
  logic             dmem_ack;
  logic             is_load;
  logic             is_store;
  logic             is_halt;
  logic             reg_write;
  logic             imem_req;
  logic             ir_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             pc_we;
  logic             rf_we;
  logic [2:0]       state;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] cycles;

  modport master (
    input  start, stop, imem_ack, dmem_ack, is_load, is_store, is_halt, reg_write,
    output imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, state, halted, err,
           retired, cycles
  );

  modport slave (
    output start, stop, imem_ack, dmem_ack, is_load, is_store, is_halt, reg_write,
    input  imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, state, halted, err,
           retired, cycles
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with
// req/ack memory handshakes, a wait watchdog and performance counters.
module cpu_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rstd,
  cpu_sequencer_if.master bus
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              waiting;
  logic              timeout_hit;
  logic              active;

  logic             imem_req_q, dmem_req_q, dmem_we_q, pc_we_q, rf_we_q;
  logic             halted_q, err_q;
  logic [CNT_W-1:0] retired_q, cycles_q;

  // A wait cycle is one spent in FETCH or MEM without the matching ack.
  assign waiting = ((state_q == S_FETCH) && !bus.imem_ack) ||
                   ((state_q == S_MEM)   && !bus.dmem_ack);

  // Fires on the TIMEOUT-th consecutive ack-less wait cycle; an ack in that cycle wins.
  assign timeout_hit = (TIMEOUT != 0) && waiting &&
                       ((32'(wait_q) + 32'd1) == 32'(TIMEOUT));

  assign active = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                  (state_q == S_EXEC)  || (state_q == S_MEM)    ||
                  (state_q == S_WB);

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    wait_d  = waiting ? wait_q + WAIT_W'(1) : '0;
    unique case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack)     state_d = S_DECODE;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_DECODE: state_d = bus.is_halt ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (bus.is_load || bus.is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dmem_ack)     state_d = S_WB;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_WB:     state_d = bus.stop ? S_IDLE : S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
  end

  // NOTE: the reset branch clears every register, so all enables drop the
  // moment rstd rises, even mid-handshake.
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      pc_we_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      retired_q  <= '0;
      cycles_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      wait_q     <= wait_d;
      imem_req_q <= (state_d == S_FETCH);
      dmem_req_q <= (state_d == S_MEM);
      // The write strobe is captured on MEM entry and held for the whole access.
      dmem_we_q  <= (state_d == S_MEM) &&
                    ((state_q == S_MEM) ? dmem_we_q : bus.is_store);
      pc_we_q    <= (state_d == S_WB);
      rf_we_q    <= (state_d == S_WB) && bus.reg_write;
      halted_q   <= (state_d == S_HALT);
      err_q      <= (state_d == S_ERR);
      if (state_q == S_WB) retired_q <= retired_q + CNT_W'(1);
      if (active)          cycles_q  <= cycles_q + CNT_W'(1);
    end
  end

  // ir_we is the one Mealy output: it follows imem_ack within the FETCH cycle.
  assign bus.ir_we    = (state_q == S_FETCH) && bus.imem_ack;
  assign bus.imem_req = imem_req_q;
  assign bus.dmem_req = dmem_req_q;
  assign bus.dmem_we  = dmem_we_q;
  assign bus.pc_we    = pc_we_q;
  assign bus.rf_we    = rf_we_q;
  assign bus.state    = state_q;
  assign bus.halted   = halted_q;
  assign bus.err      = err_q;
  assign bus.retired  = retired_q;
  assign bus.cycles   = cycles_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus random
// instruction streams compared against an instruction-level timing model.
module tb_cpu_sequencer;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 16;

  localparam int ST_IDLE   = 0;
  localparam int ST_FETCH  = 1;
  localparam int ST_DECODE = 2;
  localparam int ST_EXEC   = 3;
  localparam int ST_MEM    = 4;
  localparam int ST_WB     = 5;
  localparam int ST_HALT   = 6;
  localparam int ST_ERR    = 7;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;

  logic clk = 1'b0;
  logic rstd;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.CNT_W(CNT_W)) bus ();

  cpu_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rstd (rstd),
    .bus  (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int m_retired = 0;
  int m_cycles  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.imem_ack  = 1'b0;
    bus.dmem_ack  = 1'b0;
    bus.is_load   = 1'b0;
    bus.is_store  = 1'b0;
    bus.is_halt   = 1'b0;
    bus.reg_write = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first FETCH cycle.
  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Assert reset mid-cycle, then release it on a negedge.
  task automatic apply_reset();
    #2 rstd = 1'b1;
    clear_inputs();
    @(negedge clk);
    rstd      = 1'b0;
    m_retired = 0;
    m_cycles  = 0;
  endtask

  // One instruction starting at a FETCH negedge. The expected state trace is
  // built from the instruction kind and ack delays; acks are driven from the
  // trace position, and each cycle's outputs are compared with the trace.
  task automatic run_instr(input int kind, input bit rw, input int di, input int dm,
                           input bit stop_it, input bit noisy);
    int  q[$];
    int  fi;
    int  mi;
    int  s;
    bit  ia;
    bit  is_st;
    is_st = (kind == K_STORE);
    fi = 0;
    mi = 0;
    for (int i = 0; i <= di; i++) q.push_back(ST_FETCH);
    q.push_back(ST_DECODE);
    q.push_back(ST_EXEC);
    if (kind != K_ALU) for (int j = 0; j <= dm; j++) q.push_back(ST_MEM);
    q.push_back(ST_WB);

    bus.is_load   = (kind == K_LOAD);
    bus.is_store  = is_st;
    bus.is_halt   = 1'b0;
    bus.reg_write = rw;
    bus.stop      = stop_it;
    check("cycles_at_start", bus.cycles, m_cycles);

    foreach (q[i]) begin
      s = q[i];
      if (s == ST_FETCH) begin
        bus.imem_ack = (fi == di);
        fi++;
      end else begin
        bus.imem_ack = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (s == ST_MEM) begin
        bus.dmem_ack = (mi == dm);
        mi++;
      end else begin
        bus.dmem_ack = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      ia = bus.imem_ack;
      #1;
      check("state",    bus.state,    s);
      check("imem_req", bus.imem_req, (s == ST_FETCH));
      check("ir_we",    bus.ir_we,    (s == ST_FETCH) && ia);
      check("dmem_req", bus.dmem_req, (s == ST_MEM));
      check("dmem_we",  bus.dmem_we,  (s == ST_MEM) && is_st);
      check("pc_we",    bus.pc_we,    (s == ST_WB));
      check("rf_we",    bus.rf_we,    (s == ST_WB) && rw);
      m_cycles++;
      if (s == ST_WB) m_retired++;
      @(negedge clk);
    end

    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.stop     = 1'b0;
    #1;
    check("state_after_wb", bus.state, stop_it ? ST_IDLE : ST_FETCH);
    check("retired", bus.retired, m_retired);
    check("cycles",  bus.cycles,  m_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] c0;
    int          n_rand;
    rstd = 1'b1;
    clear_inputs();

    // Reset state
    #2;
    check("rst_state",    bus.state,    ST_IDLE);
    check("rst_retired",  bus.retired,  0);
    check("rst_cycles",   bus.cycles,   0);
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_halted",   bus.halted,   0);
    check("rst_err",      bus.err,      0);
    repeat (2) @(negedge clk);
    rstd = 1'b0;
    @(negedge clk);
    check("idle_hold", bus.state, ST_IDLE);

    // Three ALU ops with immediate imem_ack: 4 cycles each
    do_start();
    for (int i = 0; i < 3; i++) run_instr(K_ALU, 1'b1, 0, 0, 1'b0, 1'b0);
    check("alu3_retired", bus.retired, 3);
    check("alu3_cycles",  bus.cycles,  12);

    // Store with dmem_ack after 3 wait cycles: 8 cycles total, no rf_we
    c0 = bus.cycles;
    run_instr(K_STORE, 1'b0, 0, 3, 1'b0, 1'b0);
    check("store_len", bus.cycles - c0, 8);

    // Load with 1-cycle ack: 5 cycles
    c0 = bus.cycles;
    run_instr(K_LOAD, 1'b1, 0, 0, 1'b0, 1'b0);
    check("load_len", bus.cycles - c0, 5);

    // imem_ack arriving exactly on the watchdog limit cycle: ack wins
    run_instr(K_ALU, 1'b1, TIMEOUT - 1, 0, 1'b0, 1'b0);
    check("limit_no_err", bus.err, 0);
    // dmem_ack on the limit cycle
    run_instr(K_LOAD, 1'b0, 0, TIMEOUT - 1, 1'b0, 1'b0);
    check("limit_no_err_mem", bus.err, 0);

    // Random instruction stream with stray acks, ending with stop
    n_rand = 25;
    for (int i = 0; i < n_rand; i++) begin
      run_instr($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                $urandom_range(0, 5), $urandom_range(0, 5),
                (i == n_rand - 1), 1'b1);
    end

    // Stopped: cycles frozen while idle, then resume
    repeat (5) @(negedge clk);
    #1;
    check("stop_idle",   bus.state,  ST_IDLE);
    check("stop_frozen", bus.cycles, m_cycles);
    do_start();
    run_instr(K_ALU, 1'b1, 1, 0, 1'b0, 1'b0);
    check("resume_retired", bus.retired, m_retired);

    // Reset during MEM with dmem_req high
    bus.is_store = 1'b1;
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_mem_state", bus.state,    ST_MEM);
    check("pre_rst_dmem_req",  bus.dmem_req, 1);
    #2 rstd = 1'b1;
    #1;
    check("rst_mem_dmem_req", bus.dmem_req, 0);
    check("rst_mem_dmem_we",  bus.dmem_we,  0);
    check("rst_mem_state",    bus.state,    ST_IDLE);
    check("rst_mem_retired",  bus.retired,  0);
    check("rst_mem_cycles",   bus.cycles,   0);
    clear_inputs();
    @(negedge clk);
    rstd      = 1'b0;
    m_retired = 0;
    m_cycles  = 0;

    // Halt on the second instruction
    do_start();
    run_instr(K_ALU, 1'b1, 0, 0, 1'b0, 1'b0);
    bus.is_halt  = 1'b1;
    bus.imem_ack = 1'b1;
    #1;
    check("halt_ir_we", bus.ir_we, 1);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    #1;
    check("halt_decode", bus.state, ST_DECODE);
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("halted",       bus.halted,  1);
      check("halt_state",   bus.state,   ST_HALT);
      check("halt_retired", bus.retired, 1);
      check("halt_pc_we",   bus.pc_we,   0);
      @(negedge clk);
    end
    bus.start = 1'b0;

    // Fetch watchdog: imem_ack never arrives
    apply_reset();
    do_start();
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      check("wd_fetch_wait", bus.state, ST_FETCH);
      @(negedge clk);
    end
    #1;
    check("wd_err",      bus.err,      1);
    check("wd_state",    bus.state,    ST_ERR);
    check("wd_imem_req", bus.imem_req, 0);
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #1;
    check("wd_err_hold", bus.err, 1);
    apply_reset();
    #1;
    check("wd_cleared", bus.err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
